ring_rr_arbiter: RTL and testbench
==================================

// Module: ring_rr_arbiter
//
// PURPOSE
//   Round-robin arbiter for N requesters sharing one resource.
//   Priority is held in a one-hot ring token that rotates like a ring
//   counter. Each grant is held until the owner drops its request.
//   Sits in front of any shared counter/datapath so multiple masters
//   take turns fairly.
//
// PARAMETERS
//   N        4   number of requesters (N >= 1); width of req/gnt/ptr
//   TIMEOUT  16  max grant-hold cycles; used only if RING_ARB_TIMEOUT_EN
//
// PORTS
//   clk      in   1            single clock, rising edge
//   rst      in   1            synchronous, active-high reset
//   req      in   N            request per requester; held high while access is wanted
//   gnt      out  N            registered one-hot grant; 0 when idle
//   gnt_id   out  $clog2(N)    binary index of gnt bit (0 when gnt==0); min width 1
//   busy     out  1            1 while in GRANT state
//   ptr      out  N            current one-hot ring token (highest priority)
//   timeout  out  1            1-cycle pulse on forced release; tied 0 without macro
//
// BEHAVIOUR
//   - Reset (sync, rst=1 at an edge; overrides everything, incl. mid-grant):
//     gnt=0, gnt_id=0, busy=0, ptr=1 (bit0), timeout=0, state=IDLE,
//     mask=0, hold counter=0.
//   - FSM states: IDLE, GRANT.
//   - IDLE, (req & ~mask)==0: stay IDLE, ptr unchanged, gnt=0.
//   - IDLE, any eligible req: pick the first eligible bit from ptr upward,
//     wrapping bit N-1 -> bit 0.
//     Next edge: gnt=winner, gnt_id=index, busy=1, state=GRANT.
//     Latency from req to gnt: 1 cycle.
//   - GRANT, req[owner]=1: hold gnt unchanged. Other reqs are ignored
//     (no preemption).
//   - GRANT, req[owner]=0 at an edge: same edge sets gnt=0, busy=0,
//     ptr=rotl(gnt) (owner+1 mod N), state=IDLE.
//     A mandatory 1-cycle idle bubble separates consecutive grants.
//   - Wrap-around: ptr bit N-1 rotates to bit 0. The search wraps too.
//   - N=1: ptr is constantly 1. The grant follows req with 1-cycle latency
//     plus the bubble.
//   - gnt is always one-hot or zero; ptr is always exactly one-hot.
//   - Simultaneous owner release and new reqs: release wins. New reqs are
//     arbitered in the following IDLE cycle against the updated ptr.
//
// CONFIGURATION
//   Macro RING_ARB_TIMEOUT_EN
//   - Defined:
//     - A hold counter counts GRANT cycles.
//     - When gnt has been high for TIMEOUT cycles with req[owner] still 1,
//       the next edge forces release: gnt=0, busy=0, ptr=rotl(gnt),
//       timeout=1 for one cycle, mask[owner]=1.
//     - A masked requester is ineligible until its req is seen low;
//       that edge clears its mask bit.
//     - The counter clears on every entry to GRANT.
//   - Undefined: no counter, no mask logic (mask fixed 0), timeout tied 0.
//     The TIMEOUT parameter is unused.
//
// TESTING  (N=4, TIMEOUT=4)
//   1. rst=1 for 3 cycles, req=1111
//      -> gnt=0000, ptr=0001, busy=0, gnt_id=0 throughout reset.
//   2. req=0100 held 3 cycles, then 0
//      -> gnt=0100, gnt_id=2 one edge after req; gnt=0000, ptr=1000
//         one edge after req drops.
//   3. req=1111, each owner drops req 2 cycles after its grant, then
//      reasserts -> order 0001,0010,0100,1000,0001 (wrap), bubble between.
//   4. ptr=1000 (after test 2), req=0011 -> gnt=0001 (wrap search), ptr=0010
//      after release.
//   5. gnt=0010 active, rst=1 for one edge
//      -> next edge gnt=0000, ptr=0001, busy=0; req still set re-arbitrates
//         from bit0.
//   6. [RING_ARB_TIMEOUT_EN] req=0011 held high
//      -> gnt=0001 for 4 cycles, timeout=1 with gnt=0000, then gnt=0010.
//      Bit0 stays masked until req[0] is seen low.

Source files
------------

// File: rtl/ring_rr_arbiter.sv
// ring_rr_arbiter
//   Round-robin arbiter for N requesters sharing one resource. Priority is a
//   one-hot ring token (ptr) that moves to the bit just past the last owner
//   on every release. A grant is held until its owner drops its request.
//   One idle cycle always separates consecutive grants.
//
//   Optional feature, macro RING_ARB_TIMEOUT_EN:
//     A grant held for TIMEOUT cycles is forcibly released. The owner gets a
//     one-cycle timeout pulse and is masked until its request is seen low.
//     Without the macro there is no counter and no mask, timeout is tied 0,
//     and TIMEOUT is unused.
//
// Ports
//   clk      in   1          rising-edge clock
//   rst      in   1          synchronous active-high reset
//   req      in   N          request per requester, held while access is wanted
//   gnt      out  N          registered one-hot grant, 0 when idle
//   gnt_id   out  IDW        binary index of gnt (0 when idle)
//   busy     out  1          1 while a grant is held
//   ptr      out  N          one-hot ring token (highest-priority requester)
//   timeout  out  1          one-cycle pulse on a forced release
module ring_rr_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N-1:0]                       req,
    output logic [N-1:0]                       gnt,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_id,
    output logic                               busy,
    output logic [N-1:0]                       ptr,
    output logic                               timeout
);

    localparam int IDW = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0] ONE = N'(1);

    localparam logic [0:0] STATE_IDLE  = 1'b0;
    localparam logic [0:0] STATE_GRANT = 1'b1;

    logic [0:0]     state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [N-1:0]   ptr_q, ptr_d;
    logic           timeout_q, timeout_d;
    logic [N-1:0]   mask_q;

    logic [N-1:0]   elig;
    logic [N-1:0]   elig_hi;
    logic [N-1:0]   pick;
    logic [N-1:0]   winner;
    logic [IDW-1:0] winner_id;
    logic [N-1:0]   gnt_rot;
    logic           owner_req;

    // Token after a release: one past the current owner, wrapping N-1 -> 0.
    generate
        if (N == 1) begin : g_rot_1
            assign gnt_rot = gnt_q;
        end else begin : g_rot_n
            assign gnt_rot = {gnt_q[N-2:0], gnt_q[N-1]};
        end
    endgenerate

`ifdef RING_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  mask_d;
    logic [N-1:0]  mask_set;
`else
    // No masking in this build; TIMEOUT is folded into a sink so it is
    // visibly consumed.
    logic unused_timeout_param;
    assign unused_timeout_param = ^TIMEOUT;
    assign mask_q = '0;
`endif

    // Winner search: requests at or above the token win first (ptr - 1 is
    // the set of bits below the token). If none, wrap to the lowest
    // eligible bit. x & -x isolates the lowest set bit.
    always_comb begin
        elig      = req & ~mask_q;
        elig_hi   = elig & ~(ptr_q - ONE);
        pick      = (elig_hi != '0) ? elig_hi : elig;
        winner    = pick & (~pick + ONE);
        winner_id = '0;
        for (int i = 0; i < N; i++) begin
            if (winner[i]) begin
                winner_id = winner_id | i[IDW-1:0];
            end
        end
    end

    assign owner_req = |(req & gnt_q);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        ptr_d     = ptr_q;
        timeout_d = 1'b0;
`ifdef RING_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        mask_set  = '0;
`endif
        case (state_q)
            STATE_IDLE: begin
                if (elig != '0) begin
                    state_d  = STATE_GRANT;
                    gnt_d    = winner;
                    gnt_id_d = winner_id;
`ifdef RING_ARB_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            default: begin
                // Owner release takes precedence over everything, including
                // a timeout that would expire on the same edge.
                if (!owner_req) begin
                    state_d  = STATE_IDLE;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    ptr_d    = gnt_rot;
`ifdef RING_ARB_TIMEOUT_EN
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = STATE_IDLE;
                    gnt_d     = '0;
                    gnt_id_d  = '0;
                    ptr_d     = gnt_rot;
                    timeout_d = 1'b1;
                    mask_set  = gnt_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
`endif
                end
            end
        endcase
`ifdef RING_ARB_TIMEOUT_EN
        // A mask bit survives only while its request stays high.
        mask_d = (mask_q & req) | mask_set;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= STATE_IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            ptr_q     <= ONE;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            ptr_q     <= ptr_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef RING_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            mask_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            mask_q <= mask_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;

    logic unused_timeout_q;
    assign unused_timeout_q = timeout_q;
`endif

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = (state_q == STATE_GRANT);
    assign ptr    = ptr_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
module tb_ring_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic [3:0] ptr;
    logic       timeout;

    ring_rr_arbiter #(.N(4), .TIMEOUT(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .ptr     (ptr),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic [3:0] ptr;
        logic       to;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        if (v == 4'b0010) r = 2'd1;
        if (v == 4'b0100) r = 2'd2;
        if (v == 4'b1000) r = 2'd3;
        return r;
    endfunction

    // Drive one cycle of inputs, queue what the outputs must be after the
    // next rising edge, then take the edge and check against the queue head.
    task automatic step(input logic r_rst, input logic [3:0] r_req,
                        input logic [3:0] e_gnt, input logic [3:0] e_ptr,
                        input logic e_to, input string tag);
        exp_t e;
        @(negedge clk);
        rst = r_rst;
        req = r_req;
        e.tag  = tag;
        e.gnt  = e_gnt;
        e.id   = onehot_idx(e_gnt);
        e.busy = (e_gnt != 4'b0000);
        e.ptr  = e_ptr;
        e.to   = e_to;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        assert (gnt === e.gnt) else begin
            errors++;
            $error("FAIL %s gnt got %b want %b", e.tag, gnt, e.gnt);
        end
        checks++;
        assert (gnt_id === e.id) else begin
            errors++;
            $error("FAIL %s gnt_id got %0d want %0d", e.tag, gnt_id, e.id);
        end
        checks++;
        assert (busy === e.busy) else begin
            errors++;
            $error("FAIL %s busy got %b want %b", e.tag, busy, e.busy);
        end
        checks++;
        assert (ptr === e.ptr) else begin
            errors++;
            $error("FAIL %s ptr got %b want %b", e.tag, ptr, e.ptr);
        end
        checks++;
        assert (timeout === e.to) else begin
            errors++;
            $error("FAIL %s timeout got %b want %b", e.tag, timeout, e.to);
        end
    endtask

    initial begin
        logic [3:0] own;
        logic [3:0] nxt;
        rst = 1'b1;
        req = 4'b0000;

        // Reset held with every request high.
        step(1'b1, 4'b1111, 4'b0000, 4'b0001, 1'b0, "rst0");
        step(1'b1, 4'b1111, 4'b0000, 4'b0001, 1'b0, "rst1");
        step(1'b1, 4'b1111, 4'b0000, 4'b0001, 1'b0, "rst2");

        // Idle with no request: token stays put.
        step(1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b0, "idle");

        // Single requester 2: grant one edge later, held, release moves token.
        step(1'b0, 4'b0100, 4'b0100, 4'b0001, 1'b0, "r2_gnt");
        step(1'b0, 4'b0100, 4'b0100, 4'b0001, 1'b0, "r2_hold1");
        step(1'b0, 4'b0100, 4'b0100, 4'b0001, 1'b0, "r2_hold2");
        step(1'b0, 4'b0000, 4'b0000, 4'b1000, 1'b0, "r2_rel");

        // Token at bit3, only bits 0/1 request: search wraps to bit0.
        step(1'b0, 4'b0011, 4'b0001, 4'b1000, 1'b0, "wrap_gnt");
        step(1'b0, 4'b0011, 4'b0001, 4'b1000, 1'b0, "wrap_nopre");
        step(1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b0, "wrap_rel");

        // Full contention from token bit0: strict rotation with a bubble.
        step(1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b0, "rst_rr");
        own = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            nxt = {own[2:0], own[3]};
            step(1'b0, 4'b1111, own, own, 1'b0, "rr_gnt");
            step(1'b0, 4'b1111, own, own, 1'b0, "rr_hold");
            // Owner drops while others still request: release wins.
            step(1'b0, 4'b1111 & ~own, 4'b0000, nxt, 1'b0, "rr_rel");
            own = nxt;
        end
        step(1'b0, 4'b1111, 4'b0001, 4'b0001, 1'b0, "rr_wrap");

        // Reset in the middle of a grant to requester 1.
        step(1'b0, 4'b1110, 4'b0000, 4'b0010, 1'b0, "pre_rel");
        step(1'b0, 4'b1111, 4'b0010, 4'b0010, 1'b0, "g1");
        step(1'b1, 4'b1111, 4'b0000, 4'b0001, 1'b0, "mid_rst");
        step(1'b0, 4'b1111, 4'b0001, 4'b0001, 1'b0, "post_rst");
        step(1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b0, "post_rel");

`ifdef RING_ARB_TIMEOUT_EN
        // Forced release after four grant cycles, owner then masked.
        step(1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b0, "to_rst");
        step(1'b0, 4'b0011, 4'b0001, 4'b0001, 1'b0, "to_g1");
        step(1'b0, 4'b0011, 4'b0001, 4'b0001, 1'b0, "to_g2");
        step(1'b0, 4'b0011, 4'b0001, 4'b0001, 1'b0, "to_g3");
        step(1'b0, 4'b0011, 4'b0001, 4'b0001, 1'b0, "to_g4");
        step(1'b0, 4'b0011, 4'b0000, 4'b0010, 1'b1, "to_pulse");
        step(1'b0, 4'b0011, 4'b0010, 4'b0010, 1'b0, "to_next");
        step(1'b0, 4'b0001, 4'b0000, 4'b0100, 1'b0, "to_rel1");
        step(1'b0, 4'b0001, 4'b0000, 4'b0100, 1'b0, "to_masked");
        step(1'b0, 4'b0000, 4'b0000, 4'b0100, 1'b0, "to_unmask");
        step(1'b0, 4'b0001, 4'b0001, 4'b0100, 1'b0, "to_regnt");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
